cola_resultados_division: RTL and testbench
===========================================

# cola_resultados_division

Issue and collection stage wrapped around the segmented divider. It accepts operand pairs from a requester with a valid/ready handshake and drives the divider's `START`/`Num`/`Den` inputs. It captures each `{Coc, Res}` pair when `Done` pulses and buffers the pairs in an in-order FIFO for a consumer that may stall. The divider pipeline cannot stall, so this block issues work only when a FIFO slot is already reserved for its result.

## Interface
- `tamanyo`, 32: operand/result width in bits.
- `PROF`, 4: result FIFO depth; power of two, ≥ 2.
- `SERIE`, 1:
  - 1: at most one division in flight; `Num`/`Den` held until its `Done`.
  - 0: up to `PROF` divisions in flight, one issue per cycle.

Ports:
- `CLK` in 1: clock.
- `RSTa` in 1: reset; one clock; reset is synchronous and active-high.
- `Req_valid` in 1: operand pair offered.
- `Req_ready` out 1: operand pair accepted this cycle when also `Req_valid`.
- `Req_Num` in tamanyo: dividend, two's complement.
- `Req_Den` in tamanyo: divisor, two's complement.
- `START` out 1: one-cycle start pulse to divider.
- `Num` out tamanyo: dividend to divider.
- `Den` out tamanyo: divisor to divider.
- `Done` in 1: divider result-valid pulse.
- `Coc` in tamanyo: divider quotient.
- `Res` in tamanyo: divider remainder.
- `Out_valid` out 1: head result available.
- `Out_ready` in 1: consumer pops head when also `Out_valid`.
- `Out_Coc` out tamanyo: head quotient.
- `Out_Res` out tamanyo: head remainder.
- `Ocupacion` out $clog2(PROF+1): results stored in FIFO.
- `En_vuelo` out $clog2(PROF+1): accepted requests whose `Done` has not yet returned.
- `Error` out 1: sticky protocol error.

## Operation
- Acceptance: `acc = Req_valid & Req_ready`.
- `Req_ready = !RSTa & (Ocupacion + En_vuelo < PROF) & (SERIE==0 | En_vuelo==0)`. It is combinational from registered state only and never depends on `Req_valid`.
- Issue: on `acc`, register `Req_Num`/`Req_Den` into `Num`/`Den` and set `START`=1 for exactly the next cycle.
  - `Num`/`Den` hold their value until the next `acc`.
  - With `SERIE`=1 this guarantees they are stable for the whole flight.
- `En_vuelo`: +1 on `acc`, −1 on accepted `Done`; both in the same cycle leaves it unchanged.
- Capture: on `Done` with `En_vuelo` > 0, push `{Coc, Res}` into the FIFO.
  - The credit rule guarantees free space.
  - If `Done` arrives with `En_vuelo`==0 or the FIFO full, discard the pair, leave the counters unchanged, and set `Error`=1.
- FIFO: show-ahead.
  - `Out_valid` = (`Ocupacion` != 0).
  - `Out_Coc`/`Out_Res` show the head entry.
  - Pop on `Out_valid & Out_ready`.
  - Push and pop in the same cycle leave `Ocupacion` unchanged.
  - Pop on empty is ignored.
  - Read/write pointers wrap modulo `PROF`.
- Results leave in `Done` order, which equals acceptance order.
- `Error` clears only on reset.

## Timing
- Reset, when `RSTa`=1 at a rising edge:
  - `START`, `Out_valid`, `Error` = 0.
  - `Num`, `Den` = 0.
  - `Ocupacion`, `En_vuelo` = 0.
  - FIFO pointers = 0.
  - `Req_ready` = 0 while `RSTa`=1.
- Reset mid-operation discards all in-flight and buffered results. The divider must be reset by the same `RSTa`; a stale `Done` after reset sets `Error`.
- Issue latency: `acc` at edge k → `START`=1 during cycle k+1.
- Result latency: `Done` sampled at edge m → `Out_valid`=1 with that data from edge m onwards; `Ocupacion` updated at edge m.
- Throughput:
  - `SERIE`=0: one acceptance per cycle while credits remain.
  - `SERIE`=1: one per divider latency.
- `acc` and `Done` in the same cycle are both honoured.

## Structure
- Package `divisor_pkg`:
  - Default width constant `TAMANYO_DEF`=32.
  - `typedef struct packed {logic [tamanyo-1:0] coc, res;} resultado_t`, parameterised via the module-local width.
  - `$clog2` helpers for counter widths.
- One sub-module, `fifo_resultados`: synchronous show-ahead FIFO (`PROF` × 2·tamanyo) with push, pop, full, empty and count.
- Credit, `En_vuelo` and issue registers stay in the top module.

## Test plan
- Single division (`SERIE`=1, behavioural divider model, latency 33):
  - Stimulus: `Req_Num`=100, `Req_Den`=7.
  - `START` is one cycle long.
  - `Num`/`Den` hold 100/7 until `Done`.
  - `Out_Coc`=14, `Out_Res`=2.
  - `Ocupacion` goes 0→1, then →0 after pop.
- Back-pressure (`SERIE`=0, `Out_ready`=0):
  - Stimulus: 6 back-to-back requests, e.g. 100/7, −100/7, 100/−7, −100/−7, 9/3, 5/9.
  - Exactly the first 4 are accepted; `Req_ready` stays 0 afterwards.
  - `Ocupacion` reaches 4.
  - With `Out_ready`=1, results pop in order: (14,2), (−14,−2), (−14,2), (14,−2).
- Serial gating (`SERIE`=1):
  - Stimulus: two requests offered back to back.
  - The second is accepted only in the cycle after the first `Done`.
  - `En_vuelo` never exceeds 1.
- Simultaneous events:
  - Push and pop in the same cycle at `Ocupacion`=2 → stays 2.
  - `acc` coinciding with `Done` → `En_vuelo` unchanged.
- Spurious `Done`:
  - Stimulus: `Done`=1 with `En_vuelo`=0.
  - `Error`=1 and stays high; `Ocupacion` stays 0.
  - Asserting `RSTa` clears `Error`.
- Reset mid-flight:
  - Stimulus: `RSTa` pulsed with 2 results buffered and 1 division in flight.
  - All outputs return to their reset values at the next edge.
  - No result is delivered afterwards.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared constants and width helpers for the divider issue/collection stage.
// The result record type is declared inside each module so it follows the local operand width.
package divisor_pkg;

  localparam int TAMANYO_DEF = 32;
  localparam int PROF_DEF    = 4;

  // Width of a counter that must hold every value 0..prof inclusive.
  function automatic int ancho_cnt(input int prof);
    return $clog2(prof + 1);
  endfunction

  // Width of a pointer into a prof-entry array; never below one bit.
  function automatic int ancho_ptr(input int prof);
    return (prof > 1) ? $clog2(prof) : 1;
  endfunction

endpackage

// File: rtl/fifo_resultados.sv
// Synchronous show-ahead FIFO holding {quotient, remainder} records.
// Push when full and pop when empty are ignored; pointers wrap naturally because PROF is a power of two.
module fifo_resultados
  import divisor_pkg::*;
#(
  parameter int ANCHO = 2 * TAMANYO_DEF,
  parameter int PROF  = PROF_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [ANCHO-1:0]          i_dato,
  input  logic                      i_pop,
  output logic [ANCHO-1:0]          o_dato,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [ancho_cnt(PROF)-1:0] o_count
);

  localparam int AW = ancho_ptr(PROF);
  localparam int CW = ancho_cnt(PROF);

  logic [ANCHO-1:0] r_mem [PROF];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(PROF));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_dato  = r_mem[r_rd];
  assign o_count = r_count;

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_dato;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cola_resultados_division.sv
// Issue and collection stage around the non-stallable segmented divider: work is issued only
// when a FIFO slot is already reserved for its result, so every Done always finds space.
module cola_resultados_division
  import divisor_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF,
  parameter int PROF    = PROF_DEF,
  parameter int SERIE   = 1
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic                       Req_valid,
  output logic                       Req_ready,
  input  logic [tamanyo-1:0]         Req_Num,
  input  logic [tamanyo-1:0]         Req_Den,
  output logic                       START,
  output logic [tamanyo-1:0]         Num,
  output logic [tamanyo-1:0]         Den,
  input  logic                       Done,
  input  logic [tamanyo-1:0]         Coc,
  input  logic [tamanyo-1:0]         Res,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  output logic [tamanyo-1:0]         Out_Coc,
  output logic [tamanyo-1:0]         Out_Res,
  output logic [$clog2(PROF+1)-1:0]  Ocupacion,
  output logic [$clog2(PROF+1)-1:0]  En_vuelo,
  output logic                       Error
);

  localparam int CW = ancho_cnt(PROF);
  localparam logic [CW:0] PROF_L = (CW+1)'(PROF);

  typedef struct packed {
    logic [tamanyo-1:0] coc;
    logic [tamanyo-1:0] res;
  } resultado_t;

  logic               r_start;
  logic [tamanyo-1:0] r_num;
  logic [tamanyo-1:0] r_den;
  logic [CW-1:0]      r_en_vuelo;
  logic               r_error;

  logic               w_req_ready;
  logic               w_acc;
  logic               w_done_ok;
  logic               w_credito_libre;
  logic               w_serie_ok;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_ocup;
  resultado_t         w_entrada;
  resultado_t         w_cabeza;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Req_ready depends only on registered state (and reset), never on Req_valid; Out_valid
  // is high whenever the FIFO holds an entry and the head stays put until Out_ready pops it.
  assign w_credito_libre = ({1'b0, w_ocup} + {1'b0, r_en_vuelo}) < PROF_L;
  assign w_serie_ok      = (SERIE == 0) || (r_en_vuelo == '0);
  assign w_req_ready     = !RSTa && w_credito_libre && w_serie_ok;
  assign w_acc           = Req_valid && w_req_ready;

  // A Done is only trusted when a division is outstanding and a slot exists for it.
  assign w_done_ok = Done && (r_en_vuelo != '0) && !w_full;

  assign w_entrada = '{coc: Coc, res: Res};

  fifo_resultados #(
    .ANCHO (2 * tamanyo),
    .PROF  (PROF)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RSTa),
    .i_push  (w_done_ok),
    .i_dato  (w_entrada),
    .i_pop   (Out_ready),
    .o_dato  (w_cabeza),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_ocup)
  );

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      r_start    <= 1'b0;
      r_num      <= '0;
      r_den      <= '0;
      r_en_vuelo <= '0;
      r_error    <= 1'b0;
    end else begin
      r_start <= w_acc;
      if (w_acc) begin
        r_num <= Req_Num;
        r_den <= Req_Den;
      end
      case ({w_acc, w_done_ok})
        2'b10:   r_en_vuelo <= r_en_vuelo + 1'b1;
        2'b01:   r_en_vuelo <= r_en_vuelo - 1'b1;
        default: r_en_vuelo <= r_en_vuelo;
      endcase
      if (Done && !w_done_ok) begin
        r_error <= 1'b1;
      end
    end
  end

  assign Req_ready = w_req_ready;
  assign START     = r_start;
  assign Num       = r_num;
  assign Den       = r_den;
  assign Out_valid = !w_empty;
  assign Out_Coc   = w_cabeza.coc;
  assign Out_Res   = w_cabeza.res;
  assign Ocupacion = w_ocup;
  assign En_vuelo  = r_en_vuelo;
  assign Error     = r_error;

endmodule

// File: tb/tb_cola_resultados_division.sv
// Bench for cola_resultados_division: a serial instance and a pipelined instance, each fed by a
// behavioural fixed-latency signed divider, with a per-instance expected-result queue.
module tb_cola_resultados_division;

  localparam int W    = 32;
  localparam int PROF = 4;
  localparam int LAT  = 33;
  localparam int CW   = $clog2(PROF + 1);

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         acc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: SERIE=1 instance, index 1: SERIE=0 instance
  logic          rst       [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic [W-1:0]  req_num   [2];
  logic [W-1:0]  req_den   [2];
  logic          start     [2];
  logic [W-1:0]  num       [2];
  logic [W-1:0]  den       [2];
  logic          done      [2];
  logic [W-1:0]  coc       [2];
  logic [W-1:0]  res       [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [W-1:0]  out_coc   [2];
  logic [W-1:0]  out_res   [2];
  logic [CW-1:0] ocup      [2];
  logic [CW-1:0] env       [2];
  logic          err       [2];

  logic          inj_done  [2];
  logic [W-1:0]  inj_coc   [2];
  logic [W-1:0]  inj_res   [2];

  cola_resultados_division #(.tamanyo(W), .PROF(PROF), .SERIE(1)) u_dut_serie (
    .CLK(clk), .RSTa(rst[0]), .Req_valid(req_valid[0]), .Req_ready(req_ready[0]),
    .Req_Num(req_num[0]), .Req_Den(req_den[0]), .START(start[0]), .Num(num[0]), .Den(den[0]),
    .Done(done[0]), .Coc(coc[0]), .Res(res[0]), .Out_valid(out_valid[0]),
    .Out_ready(out_ready[0]), .Out_Coc(out_coc[0]), .Out_Res(out_res[0]),
    .Ocupacion(ocup[0]), .En_vuelo(env[0]), .Error(err[0])
  );

  cola_resultados_division #(.tamanyo(W), .PROF(PROF), .SERIE(0)) u_dut_segm (
    .CLK(clk), .RSTa(rst[1]), .Req_valid(req_valid[1]), .Req_ready(req_ready[1]),
    .Req_Num(req_num[1]), .Req_Den(req_den[1]), .START(start[1]), .Num(num[1]), .Den(den[1]),
    .Done(done[1]), .Coc(coc[1]), .Res(res[1]), .Out_valid(out_valid[1]),
    .Out_ready(out_ready[1]), .Out_Coc(out_coc[1]), .Out_Res(out_res[1]),
    .Ocupacion(ocup[1]), .En_vuelo(env[1]), .Error(err[1])
  );

  // ---------------- behavioural divider ----------------
  function automatic logic [W-1:0] div_coc(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
    return W'($signed(a) / $signed(b));
  endfunction

  function automatic logic [W-1:0] div_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return a;
    return W'($signed(a) % $signed(b));
  endfunction

  logic         pl_v [2][LAT];
  logic [W-1:0] pl_q [2][LAT];
  logic [W-1:0] pl_r [2][LAT];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        for (int s = 0; s < LAT; s++) pl_v[i][s] <= 1'b0;
      end else begin
        for (int s = LAT - 1; s > 0; s--) begin
          pl_v[i][s] <= pl_v[i][s-1];
          pl_q[i][s] <= pl_q[i][s-1];
          pl_r[i][s] <= pl_r[i][s-1];
        end
        pl_v[i][0] <= start[i];
        pl_q[i][0] <= div_coc(num[i], den[i]);
        pl_r[i][0] <= div_res(num[i], den[i]);
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_div
    assign done[g] = pl_v[g][LAT-1] | inj_done[g];
    assign coc[g]  = inj_done[g] ? inj_coc[g] : pl_q[g][LAT-1];
    assign res[g]  = inj_done[g] ? inj_res[g] : pl_r[g][LAT-1];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q0 [$];
  logic [2*W-1:0] exp_q1 [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic qpush(input int i, input logic [2*W-1:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  function automatic logic [2*W-1:0] qpop(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic qclear(input int i);
    if (i == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  int env_max0 = 0;

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        qclear(i);
      end else if (out_valid[i] && out_ready[i]) begin
        if (qsize(i) == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop inst=%0d actual=%0h required=none", i, {out_coc[i], out_res[i]});
        end else begin
          chk($sformatf("pop_inst%0d", i), {out_coc[i], out_res[i]}, qpop(i));
        end
      end
    end
    if (!rst[0] && int'(env[0]) > env_max0) env_max0 = int'(env[0]);
  end

  // ---------------- driver ----------------
  // Call at posedge+1; offers the pair for up to max_cyc cycles, returns at posedge+1 after the last try.
  task automatic ofrecer(input int i, input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [2*W-1:0] e, input int max_cyc, output logic acc);
    acc = 1'b0;
    req_valid[i] = 1'b1;
    req_num[i]   = n;
    req_den[i]   = d;
    for (int k = 0; k < max_cyc && !acc; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        qpush(i, e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
  endtask

  vec_t tbl [6];

  // ---------------- test sequence ----------------
  initial begin
    logic a;
    logic got;
    logic hold_bad;
    logic ready_bad;
    int   n_start;
    int   n_valid;
    int   done_cyc;
    int   acc_b_cyc;

    tbl[0] = '{num: 32'd100,      den: 32'd7,      coc: 32'd14,      res: 32'd2,      acc: 1'b1};
    tbl[1] = '{num: 32'(-100),    den: 32'd7,      coc: 32'(-14),    res: 32'(-2),    acc: 1'b1};
    tbl[2] = '{num: 32'd100,      den: 32'(-7),    coc: 32'(-14),    res: 32'd2,      acc: 1'b1};
    tbl[3] = '{num: 32'(-100),    den: 32'(-7),    coc: 32'd14,      res: 32'(-2),    acc: 1'b1};
    tbl[4] = '{num: 32'd9,        den: 32'd3,      coc: 32'd3,       res: 32'd0,      acc: 1'b0};
    tbl[5] = '{num: 32'd5,        den: 32'd9,      coc: 32'd0,       res: 32'd5,      acc: 1'b0};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_num[i] = '0; req_den[i] = '0;
      out_ready[i] = 1'b0; inj_done[i] = 1'b0; inj_coc[i] = '0; inj_res[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), req_ready[i], 0);
      chk($sformatf("rst_start%0d", i), start[i], 0);
      chk($sformatf("rst_valid%0d", i), out_valid[i], 0);
      chk($sformatf("rst_error%0d", i), err[i], 0);
      chk($sformatf("rst_ocup%0d", i), ocup[i], 0);
      chk($sformatf("rst_env%0d", i), env[i], 0);
      chk($sformatf("rst_num%0d", i), num[i], 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // single division on the serial instance
    ofrecer(0, 32'd100, 32'd7, {32'd14, 32'd2}, 4, a);
    chk("single_acc", a, 1);
    n_start = 0; hold_bad = 1'b0; got = 1'b0;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      @(negedge clk);
      if (start[0]) n_start++;
      if (num[0] !== 32'd100 || den[0] !== 32'd7) hold_bad = 1'b1;
      if (done[0]) got = 1'b1;
    end
    chk("single_done_seen", got, 1);
    chk("single_start_len", n_start, 1);
    chk("single_num_den_hold", hold_bad, 0);
    @(posedge clk); #1;
    chk("single_ocup1", ocup[0], 1);
    chk("single_valid", out_valid[0], 1);
    chk("single_coc", out_coc[0], 14);
    chk("single_res", out_res[0], 2);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("single_ocup0", ocup[0], 0);

    // serial gating: second request waits for the first Done
    out_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_num[0] = 32'd50; req_den[0] = 32'd5;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        qpush(0, {32'd10, 32'd0});
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("serie_acc_a", got, 1);
    req_num[0] = 32'(-33); req_den[0] = 32'd4;
    got = 1'b0; done_cyc = -10; acc_b_cyc = -1;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      @(negedge clk);
      if (done[0]) done_cyc = cyc;
      if (req_ready[0]) begin
        qpush(0, {32'(-8), 32'(-1)});
        acc_b_cyc = cyc;
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    chk("serie_acc_b", got, 1);
    chk("serie_acc_b_cycle", acc_b_cyc, done_cyc + 1);
    got = 1'b0;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      if (env[0] == '0 && ocup[0] == '0) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    out_ready[0] = 1'b0;
    chk("serie_drain", got, 1);
    chk("serie_env_max", env_max0, 1);
    chk("serie_q_empty", qsize(0), 0);

    // back-pressure on the pipelined instance
    out_ready[1] = 1'b0;
    for (int v = 0; v < 6; v++) begin
      ofrecer(1, tbl[v].num, tbl[v].den, {tbl[v].coc, tbl[v].res}, 1, a);
      chk($sformatf("bp_acc_vec%0d", v), a, tbl[v].acc);
    end
    ready_bad = 1'b0; got = 1'b0;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      @(negedge clk);
      if (req_ready[1]) ready_bad = 1'b1;
      if (ocup[1] == CW'(4)) got = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_ocup_reached", got, 1);
    chk("bp_ready_low", ready_bad, 0);
    chk("bp_ocup4", ocup[1], 4);
    chk("bp_ready_full", req_ready[1], 0);
    out_ready[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (ocup[1] == '0) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    out_ready[1] = 1'b0;
    chk("bp_drain", got, 1);
    chk("bp_q_empty", qsize(1), 0);

    // push and pop together at Ocupacion=2
    ofrecer(1, 32'd20, 32'd3, {32'd6, 32'd2}, 4, a);
    ofrecer(1, 32'(-20), 32'd3, {32'(-6), 32'(-2)}, 4, a);
    ofrecer(1, 32'd7, 32'd2, {32'd3, 32'd1}, 4, a);
    got = 1'b0;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      @(negedge clk);
      if (done[1] && ocup[1] == CW'(2)) begin
        got = 1'b1;
        out_ready[1] = 1'b1;
      end
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b0;
    chk("pushpop_seen", got, 1);
    chk("pushpop_ocup", ocup[1], 2);

    // acceptance in the same cycle as a Done
    ofrecer(1, 32'd11, 32'd4, {32'd2, 32'd3}, 4, a);
    chk("accdone_first_acc", a, 1);
    got = 1'b0;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      @(negedge clk);
      if (done[1]) begin
        got = 1'b1;
        req_valid[1] = 1'b1; req_num[1] = 32'd13; req_den[1] = 32'd4;
        chk("accdone_ready", req_ready[1], 1);
        if (req_ready[1]) qpush(1, {32'd3, 32'd1});
      end
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    chk("accdone_seen", got, 1);
    chk("accdone_env", env[1], 1);
    chk("accdone_ocup", ocup[1], 3);
    out_ready[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < LAT + 20 && !got; k++) begin
      if (ocup[1] == '0 && env[1] == '0) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    out_ready[1] = 1'b0;
    chk("accdone_drain", got, 1);
    chk("accdone_q_empty", qsize(1), 0);

    // spurious Done with nothing in flight
    inj_done[1] = 1'b1; inj_coc[1] = 32'hdead; inj_res[1] = 32'd1;
    @(posedge clk); #1;
    inj_done[1] = 1'b0;
    chk("spur_error", err[1], 1);
    chk("spur_ocup", ocup[1], 0);
    chk("spur_valid", out_valid[1], 0);
    repeat (3) @(posedge clk);
    #1;
    chk("spur_error_sticky", err[1], 1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("spur_error_cleared", err[1], 0);

    // reset with two results buffered and one in flight
    ofrecer(1, 32'd30, 32'd4, {32'd7, 32'd2}, 4, a);
    ofrecer(1, 32'd9, 32'd2, {32'd4, 32'd1}, 4, a);
    ofrecer(1, 32'd8, 32'd8, {32'd1, 32'd0}, 4, a);
    got = 1'b0;
    for (int k = 0; k < LAT + 10 && !got; k++) begin
      if (ocup[1] == CW'(2)) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("midrst_ocup2", got, 1);
    chk("midrst_env1", env[1], 1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("midrst_start", start[1], 0);
    chk("midrst_valid", out_valid[1], 0);
    chk("midrst_error", err[1], 0);
    chk("midrst_num", num[1], 0);
    chk("midrst_den", den[1], 0);
    chk("midrst_ocup", ocup[1], 0);
    chk("midrst_env", env[1], 0);
    chk("midrst_ready", req_ready[1], 0);
    rst[1] = 1'b0;
    out_ready[1] = 1'b1;
    n_valid = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (out_valid[1]) n_valid++;
    end
    out_ready[1] = 1'b0;
    chk("midrst_no_result", n_valid, 0);
    chk("midrst_no_error", err[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
